key_schedule_gen: RTL and testbench
===================================

# key_schedule_gen

Iterative AES key-schedule engine parametrised for AES-128/192/256. It expands a cipher key into all NR+1 round keys, producing one 32-bit word per cycle, and holds them in an internal word store. The cipher datapath reads any round key by index through a combinational port. It is the multi-key-size, full-schedule successor of the team's single-round key expansion step, and sits between key load logic and the round pipeline.

## Interface
- KEY_BITS, 128: cipher key width; legal values 128, 192, 256. Derived: NK = KEY_BITS/32, NR = NK+6, NW = 4*(NR+1) (44/52/60).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request expansion of key_in; sampled only in IDLE or DONE.
- key_in  in  KEY_BITS  cipher key; bits [KEY_BITS-1 -: 32] are w[0] (FIPS-197 byte order, first byte MSB).
- busy  out  1  high while words are being generated.
- done  out  1  level; high when all NW words are valid; held until next accepted start or reset.
- rd_round  in  4  round-key index 0..NR.
- rd_key  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] in [127:96].

## Operation
- FSM: IDLE, EXPAND, DONE.
- IDLE/DONE with start=1: write w[0..NK-1] from key_in in one edge; set i=NK, phase counter p=0 (i mod NK), rcon=0x01; clear done; go to EXPAND.
- EXPAND, each edge: temp=w[i-1]; if p==0, temp=SubWord(RotWord(temp)) ^ {rcon,24'h0} and rcon <= xtime(rcon); else if NK==8 and p==4, temp=SubWord(temp). Write w[i]=w[i-NK]^temp; i<=i+1; p wraps at NK-1.
- The edge that writes w[NW-1] also sets done=1 and moves to DONE.
- RotWord: rotate left one byte. SubWord: four parallel AES S-box lookups through the team's subByte block. xtime: GF(2^8) doubling with 0x1b reduction; rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
- start in EXPAND: ignored. start in DONE: full restart from the new key_in.
- rd_key = 0 when done==0 or rd_round>NR; otherwise the selected round key, combinationally.
- No division or modulo in RTL; use counters i and p.

## Timing
- Reset: state=IDLE, busy=0, done=0, i=0, p=0, rcon=0x01. The word store is not cleared, and rd_key reads 0 via the done gate.
- Start accepted at edge E. busy=1 after E. The last word is written and done=1/busy=0 after edge E+(NW-NK), i.e. 40/46/52 cycles.
- busy and done are never both high.
- Reset asserted mid-EXPAND: the next edge forces IDLE with busy=0 and done=0; the partial schedule is discarded. start in the same cycle as reset is ignored.
- rd_key has zero-cycle read latency. It is valid in the first cycle done is high.

## Configuration
- KEYSCHED_INV_EN defined: adds input rd_inv (1 bit). When rd_inv=1, done=1 and 1<=rd_round<=NR-1, rd_key returns InvMixColumns applied to each of the four words (equivalent-inverse-cipher keys). Rounds 0 and NR are returned unchanged. rd_inv=0 behaves as without the macro.
- Not defined: no rd_inv port and no InvMixColumns logic.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done after 40 cycles; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round=11 -> 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 cycles; round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles; round 14 = fe4890d1e6188d0b046df344706c631e (exercises the p==4 SubWord path).
- AES-128: assert reset at cycle 20 of EXPAND -> busy=0, done=0, rd_key=0. A new start then produces the same round-10 value after 40 cycles. A start pulse during EXPAND is ignored, and completion time is unchanged.
- Restart from DONE with the all-zero key (AES-128) -> done drops the next cycle; round 1 = 62636363626363636263636362636363 after 40 cycles.
- KEYSCHED_INV_EN, AES-128 FIPS key, rd_inv=1: rounds 0 and 10 equal the forward keys; round 1 matches the software InvMixColumns model. A unit check in the bench confirms word 01010101 maps to 01010101.

Source files
------------

// File: rtl/key_schedule_gen.sv
//------------------------------------------------------------------------------
// Module   : key_schedule_gen
// Desc     : Iterative AES-128/192/256 key expansion, one word per cycle, into
//            a word store with a combinational round-key read port.
//            Optional macro KEYSCHED_INV_EN adds rd_inv (InvMixColumns keys).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_schedule_gen #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
`ifdef KEYSCHED_INV_EN
  input  logic                rd_inv,
`endif
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key
);

  localparam int         c_NK    = KEY_BITS >> 5;
  localparam int         c_NR    = c_NK + 6;
  localparam int         c_NW    = 4 * (c_NR + 1);
  localparam logic [5:0] c_INIT  = 6'(c_NK);
  localparam logic [5:0] c_ILAST = 6'(c_NW - 1);
  localparam logic [2:0] c_PLAST = 3'(c_NK - 1);
  localparam logic [3:0] c_NR4   = 4'(c_NR);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_i;
  logic [2:0]  r_p;
  logic [7:0]  r_rcon;
  logic [31:0] r_w [c_NW];
  logic        w_accept;
  logic [31:0] w_prev, w_back, w_temp, w_new;

  function automatic logic [7:0] f_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, t;
    acc = 8'h00;
    t   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ t;
      t = f_xtime(t);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (x^254 addition chain) followed by the affine map
  function automatic logic [7:0] f_sbox(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = f_gmul(f_gmul(a, a), a);
    x7   = f_gmul(f_gmul(x3, x3), a);
    x15  = f_gmul(f_gmul(x7, x7), a);
    x31  = f_gmul(f_gmul(x15, x15), a);
    x63  = f_gmul(f_gmul(x31, x31), a);
    x127 = f_gmul(f_gmul(x63, x63), a);
    inv  = f_gmul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] f_subword(input logic [31:0] w);
    return {f_sbox(w[31:24]), f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0])};
  endfunction

  assign w_accept = !reset && start && (r_state != S_EXPAND);
  assign busy     = (r_state == S_EXPAND);
  assign done     = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_EXPAND;
      S_EXPAND:       if (r_i == c_ILAST) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_prev = r_w[r_i - 6'd1];
    w_back = r_w[r_i - c_INIT];
    w_temp = w_prev;
    if (r_p == 3'd0)
      w_temp = f_subword({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    else if (c_NK == 8 && r_p == 3'd4)
      w_temp = f_subword(w_prev);
    w_new = w_back ^ w_temp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i    <= 6'd0;
      r_p    <= 3'd0;
      r_rcon <= 8'h01;
    end else if (w_accept) begin
      r_i    <= c_INIT;
      r_p    <= 3'd0;
      r_rcon <= 8'h01;
    end else if (r_state == S_EXPAND) begin
      r_i <= r_i + 6'd1;
      r_p <= (r_p == c_PLAST) ? 3'd0 : r_p + 3'd1;
      if (r_p == 3'd0) r_rcon <= f_xtime(r_rcon);
    end
  end

  // Word store is deliberately not reset; reads are gated by done instead
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < c_NK; k++)
        r_w[k] <= key_in[KEY_BITS-1-32*k -: 32];
    end else if (!reset && r_state == S_EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  logic [3:0]   w_ri;
  logic [5:0]   w_base;
  logic [127:0] w_fwd;

  assign w_ri   = (rd_round > c_NR4) ? 4'd0 : rd_round;
  assign w_base = {w_ri, 2'b00};
  assign w_fwd  = {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};

`ifdef KEYSCHED_INV_EN
  function automatic logic [31:0] f_imc(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {f_gmul(a0, 8'h0e) ^ f_gmul(a1, 8'h0b) ^ f_gmul(a2, 8'h0d) ^ f_gmul(a3, 8'h09),
            f_gmul(a0, 8'h09) ^ f_gmul(a1, 8'h0e) ^ f_gmul(a2, 8'h0b) ^ f_gmul(a3, 8'h0d),
            f_gmul(a0, 8'h0d) ^ f_gmul(a1, 8'h09) ^ f_gmul(a2, 8'h0e) ^ f_gmul(a3, 8'h0b),
            f_gmul(a0, 8'h0b) ^ f_gmul(a1, 8'h0d) ^ f_gmul(a2, 8'h09) ^ f_gmul(a3, 8'h0e)};
  endfunction

  logic [127:0] w_sel;
  always_comb begin
    w_sel = w_fwd;
    if (rd_inv && rd_round != 4'd0 && rd_round != c_NR4)
      w_sel = {f_imc(w_fwd[127:96]), f_imc(w_fwd[95:64]), f_imc(w_fwd[63:32]), f_imc(w_fwd[31:0])};
  end
  assign rd_key = (done && rd_round <= c_NR4) ? w_sel : 128'h0;
`else
  assign rd_key = (done && rd_round <= c_NR4) ? w_fwd : 128'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_schedule_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_key_schedule_gen
// Desc     : Directed bench for key_schedule_gen at all three key sizes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_schedule_gen;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [127:0] key_a = '0;
  logic [191:0] key_b = '0;
  logic [255:0] key_c = '0;
  logic [3:0]   rd_a = '0, rd_b = '0, rd_c = '0;
  logic         busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [127:0] rk_a, rk_b, rk_c;
`ifdef KEYSCHED_INV_EN
  logic         inv_a = 1'b0;
`endif

  int n_asserts = 0;
  int n_fails   = 0;
  int cnt;

  localparam logic [127:0] c_K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] c_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 clk = ~clk;

  key_schedule_gen #(.KEY_BITS(128)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .key_in(key_a),
    .busy(busy_a), .done(done_a),
`ifdef KEYSCHED_INV_EN
    .rd_inv(inv_a),
`endif
    .rd_round(rd_a), .rd_key(rk_a));

  key_schedule_gen #(.KEY_BITS(192)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .key_in(key_b),
    .busy(busy_b), .done(done_b),
`ifdef KEYSCHED_INV_EN
    .rd_inv(1'b0),
`endif
    .rd_round(rd_b), .rd_key(rk_b));

  key_schedule_gen #(.KEY_BITS(256)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .key_in(key_c),
    .busy(busy_c), .done(done_c),
`ifdef KEYSCHED_INV_EN
    .rd_inv(1'b0),
`endif
    .rd_round(rd_c), .rd_key(rk_c));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input int s);
    case (s)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic sel_busy(input int s);
    case (s)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Called at posedge+1; pulses start across one edge and zeroes the cycle count
  task automatic kick(input int s);
    case (s)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    cnt = 0;
    chk("busy_after_start", 128'(sel_busy(s)), 128'd1);
    chk("done_after_start", 128'(sel_done(s)), 128'd0);
  endtask

  task automatic wait_done(input int s, input int exp_cycles, input string tag);
    while (!sel_done(s) && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (sel_busy(s) && sel_done(s)) chk("busy_done_both", 128'd1, 128'd0);
    end
    chk(tag, 128'(cnt), 128'(exp_cycles));
    chk("busy_at_done", 128'(sel_busy(s)), 128'd0);
  endtask

  task automatic rd128(input logic [3:0] r, input logic [127:0] exp, input string tag);
    rd_a = r; #1;
    chk(tag, rk_a, exp);
  endtask

`ifdef KEYSCHED_INV_EN
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00, t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r ^= t;
      t = t[7] ? ((t << 1) ^ 8'h1b) : (t << 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] m_imc(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] c [4];
    logic [7:0] o [4];
    c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int k = 0; k < 4; k++) a[k] = w[31-8*k -: 8];
    for (int r = 0; r < 4; r++) begin
      o[r] = 8'h00;
      for (int k = 0; k < 4; k++) o[r] ^= m_mul(a[k], c[(k - r + 4) % 4]);
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction
`endif

  initial begin
    logic [127:0] exp_inv;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy_a), 128'd0);
    chk("reset_done", 128'(done_a), 128'd0);
    rd128(4'd0, 128'h0, "reset_rdkey");
    reset = 1'b0;
    @(posedge clk); #1;

    // AES-128 FIPS key
    key_a = c_K128;
    kick(0);
    rd128(4'd0, 128'h0, "rdkey_gated_busy");
    wait_done(0, 40, "aes128_cycles");
    rd128(4'd0, c_K128, "aes128_r0");
    rd128(4'd1, c_R1, "aes128_r1");
    rd128(4'd10, c_R10, "aes128_r10");
    rd128(4'd11, 128'h0, "aes128_r11");
    rd128(4'd15, 128'h0, "aes128_r15");

`ifdef KEYSCHED_INV_EN
    chk("imc_unit", 128'(m_imc(32'h01010101)), 128'h01010101);
    inv_a = 1'b1;
    rd128(4'd0, c_K128, "inv_r0");
    rd128(4'd10, c_R10, "inv_r10");
    exp_inv = {m_imc(c_R1[127:96]), m_imc(c_R1[95:64]), m_imc(c_R1[63:32]), m_imc(c_R1[31:0])};
    rd128(4'd1, exp_inv, "inv_r1");
    inv_a = 1'b0;
    rd128(4'd1, c_R1, "inv_off_r1");
`endif

    // AES-192
    key_b = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    kick(1);
    wait_done(1, 46, "aes192_cycles");
    rd_b = 4'd0; #1;
    chk("aes192_r0", rk_b, 128'h8e73b0f7da0e6452c810f32b809079e5);
    rd_b = 4'd12; #1;
    chk("aes192_r12", rk_b, 128'he98ba06f448c773c8ecc720401002202);
    rd_b = 4'd13; #1;
    chk("aes192_r13", rk_b, 128'h0);

    // AES-256
    key_c = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    kick(2);
    wait_done(2, 52, "aes256_cycles");
    rd_c = 4'd0; #1;
    chk("aes256_r0", rk_c, 128'h603deb1015ca71be2b73aef0857d7781);
    rd_c = 4'd14; #1;
    chk("aes256_r14", rk_c, 128'hfe4890d1e6188d0b046df344706c631e);
    rd_c = 4'd15; #1;
    chk("aes256_r15", rk_c, 128'h0);

    // Restart from DONE with the all-zero key
    @(posedge clk); #1;
    key_a = 128'h0;
    kick(0);
    wait_done(0, 40, "zero_cycles");
    rd128(4'd1, 128'h62636363626363636263636362636363, "zero_r1");

    // Reset in mid-expansion, with a start in the same cycle
    key_a = c_K128;
    kick(0);
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start_a = 1'b0;
    chk("midrst_busy", 128'(busy_a), 128'd0);
    chk("midrst_done", 128'(done_a), 128'd0);
    rd128(4'd10, 128'h0, "midrst_rdkey");
    @(posedge clk); #1;
    chk("midrst_idle", 128'(busy_a), 128'd0);

    // Fresh start with a stray start pulse during EXPAND
    kick(0);
    repeat (10) begin @(posedge clk); #1; cnt++; end
    key_a = 128'h0; start_a = 1'b1;
    @(posedge clk); #1; cnt++;
    start_a = 1'b0;
    wait_done(0, 40, "ignore_start_cycles");
    rd128(4'd10, c_R10, "ignore_start_r10");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
